// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package dmem_access_ctrl_pkg;

  // Datapath / address width used across the core
  localparam int DMEM_N = 32;

  // Default cycle budget for REQ+WAIT before an access is aborted
  localparam int DMEM_TIMEOUT = 16;

  // Word accesses must have these address bits clear
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_wait_timer.sv
// Saturating cycle counter that bounds how long an access may sit in REQ/WAIT.
module dmem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT - 1));

  // Clear has priority; the count parks at TIMEOUT-1 so a late grant still times out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues req/gnt/rvalid transactions,
// stalls the pipeline while an access is outstanding and reports faults.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int N       = DMEM_N,
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         mem_r_en,
  input  logic         mem_w_en,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] st_val,
  input  logic         flush,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_gnt,
  input  logic         dmem_rvalid,
  input  logic [N-1:0] dmem_rdata,
  output logic         stall,
  output logic [N-1:0] ld_data,
  output logic         ld_valid,
  output logic         access_err
);

  dmem_state_t state;
  logic        drop;
  logic        op_valid;
  logic        both_en;
  logic        misalign;
  logic        op_err;
  logic        start;
  logic        tmr_clear;
  logic        tmr_en;
  logic        expired;

  assign op_valid = (mem_r_en | mem_w_en) & ~flush;
  assign both_en  = mem_r_en & mem_w_en & ~flush;
  assign misalign = |(addr[1:0] & ALIGN_MASK);
  assign op_err   = both_en | (op_valid & misalign);
  assign start    = op_valid & ~op_err;

  // Stall rises in the same cycle a legal op is seen; a flush in REQ releases it at once.
  assign stall = ((state == IDLE) & start) |
                 ((state == REQ) & ~flush) |
                 (state == WAIT);

  assign tmr_clear = (state == IDLE) & start;
  assign tmr_en    = (state == REQ) | (state == WAIT);

  dmem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (expired)
  );

  // Access FSM with registered memory-port and result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      ld_data    <= '0;
      ld_valid   <= 1'b0;
      access_err <= 1'b0;
      drop       <= 1'b0;
    end else begin
      ld_valid   <= 1'b0;
      access_err <= 1'b0;
      unique case (state)
        IDLE: begin
          drop <= 1'b0;
          if (op_err) begin
            access_err <= 1'b1;
          end else if (op_valid) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_w_en;
            dmem_addr  <= addr;
            dmem_wdata <= st_val;
            state      <= REQ;
          end
        end
        REQ: begin
          // An accepted request is committed even if a flush arrives with the grant.
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              state <= DONE;
            end else begin
              drop  <= flush;
              state <= WAIT;
            end
          end else if (flush) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else if (expired) begin
            dmem_req   <= 1'b0;
            access_err <= 1'b1;
            state      <= DONE;
          end
        end
        WAIT: begin
          if (flush) begin
            drop <= 1'b1;
          end
          // The read cannot be recalled, so a flushed load still waits and then discards.
          if (dmem_rvalid) begin
            if (!(drop || flush)) begin
              ld_data  <= dmem_rdata;
              ld_valid <= 1'b1;
            end
            state <= DONE;
          end else if (expired) begin
            access_err <= ~(drop | flush);
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
